// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} add_state_t;

endpackage

// File: rtl/nibble_shift_reg.sv
// WIDTH-bit register with parallel load, right shift by one nibble and
// serial nibble insert at the top. Synchronous active-low reset.
module nibble_shift_reg
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_val_i,
  input  logic                shift_i,
  input  logic [NIBBLE_W-1:0] nib_i,
  output logic [NIBBLE_W-1:0] nib_o,
  output logic [WIDTH-1:0]    shifted_o
);

  logic [WIDTH-1:0] q_q;

  assign nib_o     = q_q[NIBBLE_W-1:0];
  assign shifted_o = {nib_i, q_q[WIDTH-1:NIBBLE_W]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= shifted_o;
    end
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder that drives one external 4-bit CLA slice per cycle.
// Define OVF_DETECT_EN to register signed overflow on Ovf; otherwise Ovf is tied low.
module nibble_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Run,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic                Cin,
  output logic                Busy,
  output logic                Done,
  output logic [WIDTH-1:0]    Sum,
  output logic                Cout,
  output logic                Ovf,
  output logic [NIBBLE_W-1:0] slice_a,
  output logic [NIBBLE_W-1:0] slice_b,
  output logic                slice_cin,
  input  logic [NIBBLE_W-1:0] slice_s,
  input  logic                slice_pg,
  input  logic                slice_gg
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW    = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  add_state_t          state_q;
  logic [CntW-1:0]     cnt_q;
  logic                carry_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;

  logic                start;
  logic                calc;
  logic                last;
  logic                carry_d;
  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [WIDTH-1:0]    s_shifted;
  logic [WIDTH-1:0]    a_shift_unused;
  logic [WIDTH-1:0]    b_shift_unused;
  logic [NIBBLE_W-1:0] s_nib_unused;

  assign start   = (state_q == IDLE) && Run;
  assign calc    = (state_q == CALC);
  assign last    = calc && (cnt_q == CntW'(NIBBLES - 1));
  assign carry_d = slice_gg | (slice_pg & carry_q);

  nibble_shift_reg #(.WIDTH(WIDTH)) u_a_reg (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (start),
    .load_val_i (A),
    .shift_i    (calc),
    .nib_i      ('0),
    .nib_o      (a_nib),
    .shifted_o  (a_shift_unused)
  );

  nibble_shift_reg #(.WIDTH(WIDTH)) u_b_reg (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (start),
    .load_val_i (B),
    .shift_i    (calc),
    .nib_i      ('0),
    .nib_o      (b_nib),
    .shifted_o  (b_shift_unused)
  );

  // Slice sums enter at the top, so after NIBBLES shifts the result is aligned.
  nibble_shift_reg #(.WIDTH(WIDTH)) u_s_reg (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (start),
    .load_val_i ('0),
    .shift_i    (calc),
    .nib_i      (slice_s),
    .nib_o      (s_nib_unused),
    .shifted_o  (s_shifted)
  );

  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (calc) begin
      slice_a   = a_nib;
      slice_b   = b_nib;
      slice_cin = carry_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Run) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            carry_q <= Cin;
          end
        end
        CALC: begin
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            // Publish only the complete result; Sum never shows partial nibbles.
            state_q <= DONE;
            done_q  <= 1'b1;
            sum_q   <= s_shifted;
            cout_q  <= carry_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVF_DETECT_EN
  logic ovf_q;

  // Carry into the MSB xor carry out, recovered from the MSB nibble's bits.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ slice_s[NIBBLE_W-1] ^ carry_d;
    end
  end

  assign Ovf = ovf_q;
`else
  assign Ovf = 1'b0;
`endif

  assign Busy = busy_q;
  assign Done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule
